// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter driving the shared 2:1 select path.
// The winning operand is buffered in a single-entry valid/ready output stage.
module mux_sel_arbiter #(
    parameter int unsigned DW   = 4,
    parameter bit          FAIR = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [DW-1:0] in0,
    input  logic          req1,
    input  logic [DW-1:0] in1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          sel,
    output logic          last
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL0 = 2'd1,
        FULL1 = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          out_valid_d;
    logic [DW-1:0] out_data_d;
    logic          sel_d;
    logic          last_d;
    logic          accept_c;

    // Buffer, select and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 1'b0;
            last      <= 1'b1;
        end else begin
            state_q   <= state_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            sel       <= sel_d;
            last      <= last_d;
        end
    end

    // Arbitration and next-state; a drain and a refill may share one edge
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        sel_d       = sel;
        last_d      = last;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        accept_c    = !reset && ((state_q == EMPTY) || (out_valid && out_ready));

        if (accept_c) begin
            if (req0 && req1) begin
                // On contention the requester not granted last time wins
                if (FAIR && !last) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt0 = 1'b1;
                end
            end else if (req0) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end

            if (gnt0) begin
                state_d     = FULL0;
                out_valid_d = 1'b1;
                out_data_d  = in0;
                sel_d       = 1'b0;
                last_d      = 1'b0;
            end else if (gnt1) begin
                state_d     = FULL1;
                out_valid_d = 1'b1;
                out_data_d  = in1;
                sel_d       = 1'b1;
                last_d      = 1'b1;
            end else begin
                // Drained with nothing to refill; data and sel keep old values
                state_d     = EMPTY;
                out_valid_d = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed bench for mux_sel_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus.
module tb_mux_sel_arbiter;

    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req0;
    logic [DW-1:0] in0;
    logic          req1;
    logic [DW-1:0] in1;
    logic          out_ready;

    logic          gnt0, gnt1, out_valid, sel, last;
    logic [DW-1:0] out_data;
    logic          fp_gnt0, fp_gnt1, fp_out_valid, fp_sel, fp_last;
    logic [DW-1:0] fp_out_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_sel_arbiter #(.DW(DW), .FAIR(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .gnt0(gnt0), .gnt1(gnt1),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .sel(sel), .last(last)
    );

    mux_sel_arbiter #(.DW(DW), .FAIR(1'b0)) dut_fp (
        .clk(clk), .reset(reset),
        .req0(req0), .in0(in0), .req1(req1), .in1(in1),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_ready(out_ready),
        .sel(fp_sel), .last(fp_last)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; gnt is sampled 1 ns later
    task automatic drive(input logic r, input logic q0, input logic [3:0] d0,
                         input logic q1, input logic [3:0] d1, input logic rdy);
        @(negedge clk);
        reset = r; req0 = q0; in0 = d0; req1 = q1; in1 = d1; out_ready = rdy;
        #1;
    endtask

    task automatic edge_wait;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t5_data [4];

    initial begin
        reset = 1'b1; req0 = 1'b0; in0 = '0; req1 = 1'b0; in1 = '0; out_ready = 1'b0;
        t5_data = '{4'h1, 4'h9, 4'h2, 4'hA};

        // Reset state
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        edge_wait();
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        edge_wait();
        chk("rst_valid", 4'(out_valid), 4'h0);
        chk("rst_data",  out_data,      4'h0);
        chk("rst_sel",   4'(sel),       4'h0);
        chk("rst_last",  4'(last),      4'h1);

        // Single request from requester 0
        drive(1'b0, 1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
        chk("t1_gnt0", 4'(gnt0), 4'h1);
        chk("t1_gnt1", 4'(gnt1), 4'h0);
        edge_wait();
        chk("t1_valid", 4'(out_valid), 4'h1);
        chk("t1_data",  out_data,      4'hA);
        chk("t1_sel",   4'(sel),       4'h0);
        chk("t1_last",  4'(last),      4'h0);

        // Drain without refill: valid drops, data and sel hold
        drive(1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        chk("drain_gnt0", 4'(gnt0), 4'h0);
        edge_wait();
        chk("drain_valid", 4'(out_valid), 4'h0);
        chk("drain_data",  out_data,      4'hA);
        chk("drain_sel",   4'(sel),       4'h0);

        // Re-reset so last=1 and requester 0 wins the first contention
        drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        edge_wait();

        // Continuous contention: alternation (fair) versus requester 0 always (fixed)
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
            chk($sformatf("t2_gnt0_%0d", i), 4'(gnt0), (i % 2 == 0) ? 4'h1 : 4'h0);
            chk($sformatf("t2_gnt1_%0d", i), 4'(gnt1), (i % 2 == 0) ? 4'h0 : 4'h1);
            chk($sformatf("t3_gnt0_%0d", i), 4'(fp_gnt0), 4'h1);
            chk($sformatf("t3_gnt1_%0d", i), 4'(fp_gnt1), 4'h0);
            edge_wait();
            chk($sformatf("t2_data_%0d", i), out_data, (i % 2 == 0) ? 4'h3 : 4'hC);
            chk($sformatf("t2_sel_%0d", i),  4'(sel),  (i % 2 == 0) ? 4'h0 : 4'h1);
            chk($sformatf("t2_valid_%0d", i), 4'(out_valid), 4'h1);
            chk($sformatf("t3_data_%0d", i), fp_out_data, 4'h3);
            chk($sformatf("t3_sel_%0d", i),  4'(fp_sel),  4'h0);
        end

        // Backpressure: full buffer, consumer stalled, requester 1 waiting
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b0);
            chk($sformatf("t4_gnt1_%0d", i), 4'(gnt1), 4'h0);
            edge_wait();
            chk($sformatf("t4_data_%0d", i),  out_data,      4'hC);
            chk($sformatf("t4_valid_%0d", i), 4'(out_valid), 4'h1);
            chk($sformatf("t4_last_%0d", i),  4'(last),      4'h1);
        end
        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h5, 1'b1);
        chk("t4_gnt1_rel", 4'(gnt1), 4'h1);
        edge_wait();
        chk("t4_data_rel", out_data, 4'h5);
        chk("t4_sel_rel",  4'(sel),  4'h1);

        // Back-to-back alternating single requests, one operand per cycle
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, t5_data[i], 1'b0, 4'h0, 1'b1);
            else            drive(1'b0, 1'b0, 4'h0, 1'b1, t5_data[i], 1'b1);
            chk($sformatf("t5_gnt0_%0d", i), 4'(gnt0), (i % 2 == 0) ? 4'h1 : 4'h0);
            chk($sformatf("t5_gnt1_%0d", i), 4'(gnt1), (i % 2 == 0) ? 4'h0 : 4'h1);
            edge_wait();
            chk($sformatf("t5_valid_%0d", i), 4'(out_valid), 4'h1);
            chk($sformatf("t5_data_%0d", i),  out_data,      t5_data[i]);
            chk($sformatf("t5_sel_%0d", i),   4'(sel),       (i % 2 == 0) ? 4'h0 : 4'h1);
        end

        // Reset mid-operation with a full buffer and requester 1 pending
        drive(1'b1, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1);
        chk("t6_gnt0", 4'(gnt0), 4'h0);
        chk("t6_gnt1", 4'(gnt1), 4'h0);
        chk("t6_fp_gnt1", 4'(fp_gnt1), 4'h0);
        edge_wait();
        chk("t6_valid", 4'(out_valid), 4'h0);
        chk("t6_sel",   4'(sel),       4'h0);
        chk("t6_last",  4'(last),      4'h1);
        chk("t6_data",  out_data,      4'h0);

        drive(1'b0, 1'b0, 4'h0, 1'b1, 4'h7, 1'b1);
        chk("t6_post_gnt1", 4'(gnt1), 4'h1);
        edge_wait();
        chk("t6_post_data", out_data, 4'h7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
